// File: rtl/datapath_responder.sv
// datapath_responder: executes one DRAW / NNMEMREAD / NOP instruction per start handshake
module datapath_responder #(
  parameter int OPCODE_WIDTH      = 3,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int X_WIDTH           = 8,
  parameter int Y_WIDTH           = 7,
  parameter int COLOUR_WIDTH      = 3,
  parameter int ADDR_WIDTH        = 6,
  parameter int DATA_WIDTH        = 16,
  parameter int RESULT_WIDTH      = 16,
  parameter int MEM_LATENCY       = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         finished,
  output logic [RESULT_WIDTH-1:0]      result,
  output logic [X_WIDTH-1:0]           vga_x,
  output logic [Y_WIDTH-1:0]           vga_y,
  output logic [COLOUR_WIDTH-1:0]      vga_colour,
  output logic                         vga_plot,
  output logic [ADDR_WIDTH-1:0]        mem_address,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic                         bad_opcode
);
  localparam int OW = OPCODE_WIDTH;
  localparam int YL = OW + X_WIDTH;
  localparam int CL = YL + Y_WIDTH;
  localparam int PL = CL + COLOUR_WIDTH;
  localparam int WW = $clog2(MEM_LATENCY + 1);
  localparam logic [OW-1:0] OP_NOP = OW'(0);
  localparam logic [OW-1:0] OP_DRAW = OW'(1);
  localparam logic [OW-1:0] OP_MEM = OW'(2);
  typedef enum logic [1:0] {IDLE, DECODE, DRAW_PULSE, MEM_WAIT} state_t;
  state_t state;
  logic armed;
  logic [WW-1:0] wait_count;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic [OW-1:0] opcode;
  logic unused_bits;
  assign opcode = instr_q[OW-1:0];
  assign unused_bits = ^instr_q[INSTRUCTION_WIDTH-1:PL+1];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      finished <= 1'b1;
      result <= '0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
      mem_address <= '0;
      bad_opcode <= 1'b0;
      armed <= 1'b0;
      instr_q <= '0;
      wait_count <= '0;
    end else begin
      // arming requires seeing start low, so a held start cannot re-trigger
      if (!start) armed <= 1'b1;
      case (state)
        IDLE: if (start && armed) begin
          instr_q <= instruction;
          mem_address <= instruction[OW+ADDR_WIDTH-1:OW];
          finished <= 1'b0;
          armed <= 1'b0;
          state <= DECODE;
        end
        DECODE: if (opcode == OP_DRAW) begin
          vga_x <= instr_q[YL-1:OW];
          vga_y <= instr_q[CL-1:YL];
          vga_colour <= instr_q[PL-1:CL];
          vga_plot <= instr_q[PL];
          state <= DRAW_PULSE;
        end else if (opcode == OP_MEM) begin
          wait_count <= WW'(MEM_LATENCY);
          state <= MEM_WAIT;
        end else begin
          result <= (opcode == OP_NOP) ? '0 : '1;
          bad_opcode <= bad_opcode | (opcode != OP_NOP);
          finished <= 1'b1;
          state <= IDLE;
        end
        DRAW_PULSE: begin
          vga_plot <= 1'b0;
          result <= '0;
          finished <= 1'b1;
          state <= IDLE;
        end
        MEM_WAIT: if (wait_count == WW'(1)) begin
          result <= RESULT_WIDTH'(mem_data);
          finished <= 1'b1;
          state <= IDLE;
        end else begin
          wait_count <= wait_count - WW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
